trig_coinc_engine: RTL

Parametrised multi-threshold coincidence trigger engine for the trigger board, running in the `clk_adc` domain between the LVDS/coax input buffers and the coax trigger outputs. It stretches each masked input hit into a coincidence window, counts active channels, and evaluates `NTRIG` independent multiplicity triggers under a shared prescale and global dead time. Each accepted trigger is written as a timestamped record into an on-chip FIFO, which slow control drains through a valid/ready handshake.

---
 rtl/trig_coinc_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/trig_coinc_engine.sv
// Multi-threshold coincidence trigger with prescale, dead time and record FIFO.
// Optional per-channel hit histogram enabled by defining TRIG_HISTO_EN.
module trig_coinc_engine #(
    parameter int NCH     = 64,
    parameter int NTRIG   = 8,
    parameter int CW      = 6,
    parameter int TSW     = 56,
    parameter int DEPTH   = 8,
    parameter int OUT_LEN = 16,
    parameter int NW      = $clog2(NCH + 1)
) (
    input  logic                    clk_adc,
    input  logic                    rst,
    input  logic [NCH-1:0]          coax_in,
    input  logic [NCH-1:0]          chan_mask,
    input  logic [CW-1:0]           coincidence_time,
    input  logic [7:0]              dead_time,
    input  logic [NTRIG-1:0]        trig_enable,
    input  logic [NTRIG*NW-1:0]     trig_thresh,
    input  logic [31:0]             randnum,
    input  logic [31:0]             prescale,
    input  logic                    run_gate,
    input  logic                    ts_reset,
    output logic [15:0]             coax_out,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [NTRIG-1:0]        rec_trig,
    output logic [TSW-1:0]          rec_ts,
    output logic                    fifo_full,
    output logic [15:0]             drop_count,
    input  logic [$clog2(NCH)-1:0]  hist_sel,
    output logic [31:0]             hist_out
);
    localparam int GS = 8;
    localparam int NG = (NCH + GS - 1) / GS;
    localparam int PW = $clog2(GS + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(OUT_LEN + 1);

    logic [NCH-1:0]    hit;
    logic              pass;
    logic [2:0]        pass_sr;
    logic [CW-1:0]     win [NCH];
    logic [NCH-1:0]    act;
    logic [NG*GS-1:0]  act_pad;
    logic [PW-1:0]     psum_c [NG];
    logic [PW-1:0]     psum [NG];
    logic [NW-1:0]     n_act_c;
    logic [NW-1:0]     n_act;
    logic [NTRIG-1:0]  sat;
    logic              fire;
    logic [7:0]        dead;
    logic [OW-1:0]     out_cnt;
    logic [TSW-1:0]    ts;
    logic              push;
    logic [NTRIG-1:0]  push_trig;
    logic [TSW-1:0]    push_ts;

    logic [NTRIG-1:0]  mem_trig [DEPTH];
    logic [TSW-1:0]    mem_ts [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;

    always_comb begin
        act = '0;
        for (int c = 0; c < NCH; c++) act[c] = (win[c] != '0);
        act_pad = '0;
        act_pad[NCH-1:0] = act;
    end

    // Two-level tree: group sums of GS channels, then a sum of the groups.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            psum_c[g] = '0;
            for (int j = 0; j < GS; j++)
                psum_c[g] = psum_c[g] + PW'(act_pad[g*GS+j]);
        end
        n_act_c = '0;
        for (int g = 0; g < NG; g++) n_act_c = n_act_c + NW'(psum[g]);
    end

    always_comb begin
        sat = '0;
        for (int k = 0; k < NTRIG; k++)
            sat[k] = trig_enable[k] && (n_act >= trig_thresh[k*NW +: NW]);
        fire = (|sat) && pass_sr[2] && run_gate && (dead == 8'd0);
    end

    always_ff @(posedge clk_adc) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst)
                win[c] <= '0;
            else if (hit[c])
                win[c] <= coincidence_time;
            else if (win[c] != '0)
                win[c] <= win[c] - CW'(1);
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            hit       <= '0;
            pass      <= 1'b0;
            pass_sr   <= '0;
            n_act     <= '0;
            dead      <= '0;
            out_cnt   <= '0;
            ts        <= '0;
            push      <= 1'b0;
            push_trig <= '0;
            push_ts   <= '0;
            for (int g = 0; g < NG; g++) psum[g] <= '0;
        end else begin
            hit     <= ~coax_in & chan_mask;
            pass    <= (randnum <= prescale);
            pass_sr <= {pass_sr[1:0], pass};
            for (int g = 0; g < NG; g++) psum[g] <= psum_c[g];
            n_act   <= n_act_c;
            ts      <= ts_reset ? '0 : ts + TSW'(1);
            if (fire) begin
                dead    <= dead_time;
                out_cnt <= OW'(OUT_LEN);
            end else begin
                if (dead != 8'd0) dead <= dead - 8'd1;
                if (out_cnt != '0) out_cnt <= out_cnt - OW'(1);
            end
            // Record is staged one clock so the head appears two clocks after fire.
            push      <= fire;
            push_trig <= sat;
            push_ts   <= ts;
        end
    end

    assign coax_out = {16{out_cnt != '0}};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rec_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk_adc) begin
        if (wr_en) begin
            mem_trig[wr_ptr[AW-1:0]] <= push_trig;
            mem_ts[wr_ptr[AW-1:0]]   <= push_ts;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign rec_valid = !empty;
    assign fifo_full = full;
    assign rec_trig  = empty ? '0 : mem_trig[rd_ptr[AW-1:0]];
    assign rec_ts    = empty ? '0 : mem_ts[rd_ptr[AW-1:0]];

`ifdef TRIG_HISTO_EN
    logic [31:0] hcnt [NCH];

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            hist_out <= '0;
            for (int c = 0; c < NCH; c++) hcnt[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) hcnt[c] <= hcnt[c] + 32'(hit[c]);
            hist_out <= hcnt[hist_sel];
        end
    end
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_out = '0;
`endif

endmodule
